// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the FIFO family (sync and
//               future async/CDC variants): width derivation and default
//               almost-full / almost-empty thresholds.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Pointers carry one extra wrap bit above the memory address bits.
  localparam int c_ptr_wrap_bits = 1;

  // Default thresholds: almost-empty at two words or fewer, almost-full
  // two words short of full.
  localparam int c_default_almost_empty_thr   = 2;
  localparam int c_default_almost_full_margin = 2;

  // Ceiling log2, valid for value >= 1.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Read/write pointer width for a given address width.
  function automatic int ptr_width(input int addr_length);
    return addr_length + c_ptr_wrap_bits;
  endfunction

  // Width needed to count 0..2^addr_length inclusive.
  function automatic int level_width(input int addr_length);
    return clog2((1 << addr_length) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_level_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_level_mem
// Description : Simple dual-port RAM with a synchronous write port and a
//               registered read port. The read register resets to zero and
//               holds its value when no read is issued; the array itself is
//               never cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_level_mem #(
  parameter int ADDR_LENGTH = 8,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr_en,
  input  logic [ADDR_LENGTH-1:0] i_wr_addr,
  input  logic [WORD_LENGTH-1:0] i_wr_data,
  input  logic                   i_rd_en,
  input  logic [ADDR_LENGTH-1:0] i_rd_addr,
  output logic [WORD_LENGTH-1:0] o_rd_data
);

  localparam int c_depth = 1 << ADDR_LENGTH;

  logic [WORD_LENGTH-1:0] r_mem [0:c_depth-1];
  logic [WORD_LENGTH-1:0] r_rd_data;

  // Store the write word; storage is not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Register the addressed word on a read, otherwise keep the last word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo_sync_level.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_level
// Description : Single-clock FIFO with full 2^ADDR_LENGTH capacity, registered
//               read data plus valid strobe, a fill-level counter and
//               programmable almost-full / almost-empty flags.
//               Define FIFO_SYNC_ERR_FLAGS_EN to add sticky overflow/underflow
//               flags and the i_clear_flags input.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_level
  import fifo_pkg::*;
#(
  parameter int ADDR_LENGTH      = 8,
  parameter int WORD_LENGTH      = 8,
  parameter int ALMOST_FULL_THR  = (1 << ADDR_LENGTH) - c_default_almost_full_margin,
  parameter int ALMOST_EMPTY_THR = c_default_almost_empty_thr
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [WORD_LENGTH-1:0] i_data_in,
  input  logic                   i_write_en,
  input  logic                   i_read_en,
  output logic [WORD_LENGTH-1:0] o_data_out,
  output logic                   o_data_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_almost_full,
  output logic                   o_almost_empty,
  output logic [ADDR_LENGTH:0]   o_level
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  ,
  input  logic                   i_clear_flags,
  output logic                   o_overflow,
  output logic                   o_underflow
`endif
);

  localparam int c_ptr_w = ptr_width(ADDR_LENGTH);
  localparam int c_lvl_w = level_width(ADDR_LENGTH);

  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0] c_af_thr  = c_lvl_w'(ALMOST_FULL_THR);
  localparam logic [c_lvl_w-1:0] c_ae_thr  = c_lvl_w'(ALMOST_EMPTY_THR);

  logic               w_wr_acc;
  logic               w_rd_acc;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] w_wr_ptr_nxt;
  logic [c_ptr_w-1:0] w_rd_ptr_nxt;
  logic [c_lvl_w-1:0] r_level;
  logic [c_lvl_w-1:0] w_level_nxt;
  logic               w_full_nxt;
  logic               w_empty_nxt;
  logic               r_full;
  logic               r_empty;
  logic               r_almost_full;
  logic               r_almost_empty;
  logic               r_data_valid;

  // Acceptance uses the registered flags; reset cancels both operations.
  assign w_wr_acc = i_write_en & ~r_full  & ~i_reset;
  assign w_rd_acc = i_read_en  & ~r_empty & ~i_reset;

  // Next pointers, next level and the pointer-derived full/empty state.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (w_wr_acc) begin
      w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
    end
    if (w_rd_acc) begin
      w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
    end
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + c_lvl_one;
      2'b01:   w_level_nxt = r_level - c_lvl_one;
      default: w_level_nxt = r_level;
    endcase
    // Equal pointers mean empty; same slot with opposite wrap bits means full.
    w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_full_nxt  = (w_wr_ptr_nxt[ADDR_LENGTH-1:0] == w_rd_ptr_nxt[ADDR_LENGTH-1:0]) &&
                  (w_wr_ptr_nxt[c_ptr_w-1] != w_rd_ptr_nxt[c_ptr_w-1]);
  end

  // Pointers, level and all status flags register together from next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_level        <= w_level_nxt;
      r_full         <= w_full_nxt;
      r_empty        <= w_empty_nxt;
      r_almost_full  <= (w_level_nxt >= c_af_thr);
      r_almost_empty <= (w_level_nxt <= c_ae_thr);
    end
  end

  // Valid strobe marks the cycle after each accepted read.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
    end
  end

  fifo_sync_level_mem #(
    .ADDR_LENGTH (ADDR_LENGTH),
    .WORD_LENGTH (WORD_LENGTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_LENGTH-1:0]),
    .i_wr_data (i_data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDR_LENGTH-1:0]),
    .o_rd_data (o_data_out)
  );

  assign o_data_valid   = r_data_valid;
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_level        = r_level;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic w_overflow_set;
  logic w_underflow_set;
  logic r_overflow;
  logic r_underflow;

  assign w_overflow_set  = i_write_en & r_full;
  assign w_underflow_set = i_read_en  & r_empty;

  // Sticky error flags: a set event beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end else if (i_clear_flags) begin
        r_overflow <= 1'b0;
      end
      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end else if (i_clear_flags) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_level.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_level
// Description : Scoreboard bench for fifo_sync_level (DEPTH=4). A queue-based
//               reference model predicts status and read data per cycle; a
//               monitor compares after every rising edge. Error-flag checks
//               are included when FIFO_SYNC_ERR_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_level;

  localparam int c_aw    = 2;
  localparam int c_ww    = 8;
  localparam int c_depth = 4;
  localparam int c_af    = 3;
  localparam int c_ae    = 1;

  typedef struct {
    int             level;
    bit             full;
    bit             empty;
    bit             af;
    bit             ae;
    bit             valid;
    logic [c_ww-1:0] dout;
    bit             ov;
    bit             un;
  } status_t;

  logic            clk;
  logic            rst;
  logic [c_ww-1:0] data_in;
  logic            write_en;
  logic            read_en;
  logic [c_ww-1:0] data_out;
  logic            data_valid;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic [c_aw:0]   level;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic            clear_flags;
  logic            overflow;
  logic            underflow;
`endif

  fifo_sync_level #(
    .ADDR_LENGTH      (c_aw),
    .WORD_LENGTH      (c_ww),
    .ALMOST_FULL_THR  (c_af),
    .ALMOST_EMPTY_THR (c_ae)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_data_in      (data_in),
    .i_write_en     (write_en),
    .i_read_en      (read_en),
    .o_data_out     (data_out),
    .o_data_valid   (data_valid),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_level        (level)
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    ,
    .i_clear_flags  (clear_flags),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [c_ww-1:0] mq[$];
  logic [c_ww-1:0] m_last;
  bit              m_ov;
  bit              m_un;

  // Scoreboards
  status_t         exp_st[$];
  logic [c_ww-1:0] exp_data[$];

  int n_vec;
  int n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic step(input bit wr, input bit rd, input logic [c_ww-1:0] d,
                      input bit rs, input bit clr);
    status_t s;
    bit      acc_w;
    bit      acc_r;
    bit      ov_set;
    bit      un_set;
    @(negedge clk);
    write_en = wr;
    read_en  = rd;
    data_in  = d;
    rst      = rs;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    clear_flags = clr;
`endif
    s.valid = 1'b0;
    if (rs) begin
      mq.delete();
      m_last = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      acc_w  = wr && (mq.size() < c_depth);
      acc_r  = rd && (mq.size() > 0);
      ov_set = wr && (mq.size() == c_depth);
      un_set = rd && (mq.size() == 0);
      if (acc_r) begin
        m_last  = mq.pop_front();
        s.valid = 1'b1;
        exp_data.push_back(m_last);
      end
      if (acc_w) mq.push_back(d);
      m_ov = ov_set ? 1'b1 : (clr ? 1'b0 : m_ov);
      m_un = un_set ? 1'b1 : (clr ? 1'b0 : m_un);
    end
    s.level = mq.size();
    s.full  = (s.level == c_depth);
    s.empty = (s.level == 0);
    s.af    = (s.level >= c_af);
    s.ae    = (s.level <= c_ae);
    s.dout  = m_last;
    s.ov    = m_ov;
    s.un    = m_un;
    exp_st.push_back(s);
  endtask

  // Monitor: compare status and popped read data just after each rising edge.
  initial begin
    status_t s;
    logic [c_ww-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_st.size() > 0) begin
        s = exp_st.pop_front();
        chk("level",        32'(level),        32'(s.level));
        chk("full",         32'(full),         32'(s.full));
        chk("empty",        32'(empty),        32'(s.empty));
        chk("almost_full",  32'(almost_full),  32'(s.af));
        chk("almost_empty", 32'(almost_empty), 32'(s.ae));
        chk("data_valid",   32'(data_valid),   32'(s.valid));
        chk("data_out",     32'(data_out),     32'(s.dout));
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        chk("overflow",     32'(overflow),     32'(s.ov));
        chk("underflow",    32'(underflow),    32'(s.un));
`endif
      end
      if (data_valid === 1'b1) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_data.pop_front();
          chk("rd_data", 32'(data_out), 32'(e));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    m_last   = '0;
    m_ov     = 1'b0;
    m_un     = 1'b0;
    rst      = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    clear_flags = 1'b0;
`endif

    // Reset then idle
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Fill to full, then a dropped fifth write
    for (int i = 0; i < 4; i++) step(1, 0, 8'hA1 + 8'(i), 0, 0);
    step(1, 0, 8'hA5, 0, 0);

    // Drain back-to-back, then a read while empty
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    // Simultaneous read/write at level 2
    step(1, 0, 8'hC1, 0, 0);
    step(1, 0, 8'hC2, 0, 0);
    step(1, 1, 8'hB0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);

    // Wrap-around at level 1 with continuous write+read
    step(1, 0, 8'hD0, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, 1, 8'hD0 + 8'(i), 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);

    // Reset mid-operation at level 3 with a concurrent write
    for (int i = 0; i < 3; i++) step(1, 0, 8'hE0 + 8'(i), 0, 0);
    step(1, 0, 8'hEE, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           8'($urandom), $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0);
    end

    // Drain and finish
    for (int i = 0; i < 6; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("pending_data",   32'(exp_data.size()), 32'd0);
    chk("pending_status", 32'(exp_st.size()),   32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync_level.md
# fifo_sync_level

Synchronous single-clock FIFO with full 2^ADDR_LENGTH capacity, registered read data with a valid strobe, and a fill-level counter that drives programmable almost-full and almost-empty flags. It is the general-purpose buffer between producer and consumer blocks running on the same clock, such as UART/SPI/I2C byte streams and DMA-style consumers. Sticky overflow and underflow error flags are an optional compile-time feature.

## Interface
- ADDR_LENGTH, 8: address bits; depth DEPTH = 2^ADDR_LENGTH words.
- WORD_LENGTH, 8: data word width.
- ALMOST_FULL_THR, DEPTH-2: o_almost_full asserts when level >= this value. Legal range 1..DEPTH.
- ALMOST_EMPTY_THR, 2: o_almost_empty asserts when level <= this value. Legal range 0..DEPTH-1.
- i_clk  in  1  clock; every register updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data_in  in  WORD_LENGTH  write data.
- i_write_en  in  1  write request.
- i_read_en  in  1  read request.
- i_clear_flags  in  1  clears the sticky error flags. Present only with FIFO_SYNC_ERR_FLAGS_EN.
- o_data_out  out  WORD_LENGTH  read data, registered.
- o_data_valid  out  1  one-cycle strobe: o_data_out holds a newly read word.
- o_full, o_empty  out  1  level == DEPTH / level == 0.
- o_almost_full, o_almost_empty  out  1  threshold flags.
- o_level  out  ADDR_LENGTH+1  current word count, 0..DEPTH.
- o_overflow, o_underflow  out  1  sticky error flags. Present only with FIFO_SYNC_ERR_FLAGS_EN.

## Operation
- Pointers: w_ptr and r_ptr are ADDR_LENGTH+1 bits wide. The low ADDR_LENGTH bits address memory; the MSB is the wrap bit. Both wrap modulo 2^(ADDR_LENGTH+1).
- Full: pointers have equal low bits and different MSBs. Empty: pointers are equal. All DEPTH entries are usable.
- Write acceptance: a write is accepted when i_write_en=1 and o_full=0 (value before the edge). The accepted write stores i_data_in at w_ptr and increments w_ptr. A write while full is dropped and memory is unchanged.
- Read acceptance: a read is accepted when i_read_en=1 and o_empty=0 (value before the edge). The accepted read increments r_ptr, and the next cycle presents mem[old r_ptr] on o_data_out with o_data_valid=1. A read while empty is ignored and o_data_valid stays 0.
- Simultaneous read and write:
  - Both accepted: level unchanged.
  - While full: only the read is accepted; the write is dropped.
  - While empty: only the write is accepted. There is no read-through; the word becomes readable the following cycle.
- Level update: +1 for write only, -1 for read only, 0 for both or neither.
- Flag registers: o_level and all status flags are registered from the next-state level, so they are consistent with each other in every cycle.
- o_data_out holds its last value while o_data_valid=0.
- Reset: i_reset=1 for one edge clears w_ptr, r_ptr, o_level and o_data_valid, and sets o_data_out to 0. Reset overrides any concurrent read or write in that cycle. Memory contents are not cleared.
- Reset values: o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_level=0, o_overflow=0, o_underflow=0.

## Timing
- Write to not-empty: 1 cycle. A write at edge N shows o_empty=0 and o_level=1 after edge N.
- Read to data: 1 cycle. A read accepted at edge N gives o_data_out and o_data_valid after edge N, for one cycle per accepted read.
- Sustained rate: one read and one write every cycle with no bubbles.
- Outputs: all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- FIFO_SYNC_ERR_FLAGS_EN defined:
  - o_overflow sets on a dropped write (write request while full).
  - o_underflow sets on an ignored read (read request while empty).
  - Both flags stay set until i_clear_flags=1 or i_reset=1.
  - If a set event and a clear occur in the same cycle, set wins.
- FIFO_SYNC_ERR_FLAGS_EN undefined: i_clear_flags, o_overflow and o_underflow are absent, and there is no error-tracking logic.

## Structure
- Package fifo_pkg holds:
  - a clog2 helper;
  - the pointer-width and level-width derivation constants;
  - the default threshold constants, shared with future async/CDC FIFO variants.
- Sub-module fifo_sync_level_mem: simple dual-port RAM with a synchronous write port and a registered read port, parameters ADDR_LENGTH and WORD_LENGTH. The top level contains only pointer, level and flag logic.

## Test plan
Bench parameters: ADDR_LENGTH=2 (DEPTH=4), WORD_LENGTH=8, ALMOST_FULL_THR=3, ALMOST_EMPTY_THR=1.
- Reset then idle: o_empty=1, o_almost_empty=1, o_level=0, o_data_valid=0, o_data_out=0.
- Write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles: o_level steps 1,2,3,4; o_almost_full=1 from level 3; o_full=1 at level 4. A 5th write of 0xA5 is dropped: o_level stays 4 and o_overflow=1 when the macro is enabled.
- From full, read 4 times back-to-back: o_data_out=A1,A2,A3,A4, each with o_data_valid=1 one cycle after its read. Ends with o_empty=1. A 5th read gives o_data_valid=0 and o_underflow=1.
- At level 2, read and write 0xB0 in the same cycle: o_level stays 2; the oldest word is output; 0xB0 is read out later in FIFO order.
- Wrap-around: 10 cycles of continuous write+read starting at level 1. Output data order matches input order across pointer wrap, and o_full never asserts.
- Reset mid-operation at level 3 with a concurrent write: next cycle o_level=0, o_empty=1, o_data_valid=0, and the write is discarded.
